writeback_regfile: RTL and testbench

//  Writeback stage directly downstream of the ALU: takes ALU results and CMP flag words, commits them to a
//  NUM_REGS x `REG_W general-register file with x86 partial-width rules, and holds EFLAGS.

---
 rtl/writeback_regfile_if.sv | 54 +++++
 rtl/writeback_regfile.sv | 152 +++++++++++++++
 tb/tb_writeback_regfile.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_regfile_if.sv
// Writeback / register-file bundle: issue, operand read ports, ALU writeback, EFLAGS.
// master = upstream pipeline (issue + ALU), slave = writeback_regfile.
`ifndef REG_W
`define REG_W 64
`endif
`ifndef BIT_MODE_W
`define BIT_MODE_W 2
`endif

interface writeback_regfile_if #(
  parameter int REG_ADDR_W = 4
);
  logic                   iss_valid;
  logic                   iss_ready;
  logic [REG_ADDR_W-1:0]  iss_dst;
  logic                   iss_dst_we;

  logic [REG_ADDR_W-1:0]  rs_addr;
  logic [REG_ADDR_W-1:0]  rt_addr;
  logic [`REG_W-1:0]      rs_data;
  logic [`REG_W-1:0]      rt_data;
  logic                   rs_busy;
  logic                   rt_busy;

  logic                   wb_valid;
  logic                   wb_ready;
  logic [REG_ADDR_W-1:0]  wb_dst;
  logic                   wb_we;
  logic [`REG_W-1:0]      wb_data;
  logic [`BIT_MODE_W-1:0] wb_bit_mode;
  logic                   wb_flags_we;
  logic [`REG_W-1:0]      wb_flags;
  logic [`REG_W-1:0]      eflags;

  modport master (
    output iss_valid, iss_dst, iss_dst_we,
    output rs_addr, rt_addr,
    output wb_valid, wb_dst, wb_we, wb_data,
    output wb_bit_mode, wb_flags_we, wb_flags,
    input  iss_ready,
    input  rs_data, rt_data, rs_busy, rt_busy,
    input  wb_ready, eflags
  );

  modport slave (
    input  iss_valid, iss_dst, iss_dst_we,
    input  rs_addr, rt_addr,
    input  wb_valid, wb_dst, wb_we, wb_data,
    input  wb_bit_mode, wb_flags_we, wb_flags,
    output iss_ready,
    output rs_data, rt_data, rs_busy, rt_busy,
    output wb_ready, eflags
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: x86 partial-width GPR commit, EFLAGS, s/t read ports, busy scoreboard.
// Ports: clk, rstn (async low), bus (writeback_regfile_if.slave). Option: WB_BYPASS_EN.
`ifndef REG_W
`define REG_W 64
`endif
`ifndef BIT_MODE_W
`define BIT_MODE_W 2
`endif
`ifndef BIT_MODE_8
`define BIT_MODE_8 2'd0
`endif
`ifndef BIT_MODE_16
`define BIT_MODE_16 2'd1
`endif
`ifndef BIT_MODE_32
`define BIT_MODE_32 2'd2
`endif
`ifndef BIT_MODE_64
`define BIT_MODE_64 2'd3
`endif
`ifndef EFLAGS_CF
`define EFLAGS_CF 0
`endif
`ifndef EFLAGS_PF
`define EFLAGS_PF 2
`endif
`ifndef EFLAGS_ZF
`define EFLAGS_ZF 6
`endif
`ifndef EFLAGS_SF
`define EFLAGS_SF 7
`endif
`ifndef EFLAGS_OF
`define EFLAGS_OF 11
`endif

module writeback_regfile #(
  parameter int                NUM_REGS    = 16,
  parameter int                REG_ADDR_W  = $clog2(NUM_REGS),
  parameter logic [`REG_W-1:0] EFLAGS_INIT = `REG_W'(2)
) (
  input logic                clk,
  input logic                rstn,
  writeback_regfile_if.slave bus
);

  localparam logic [`REG_W-1:0] FLAG_MASK =
    (`REG_W'(1) << `EFLAGS_CF) |
    (`REG_W'(1) << `EFLAGS_PF) |
    (`REG_W'(1) << `EFLAGS_ZF) |
    (`REG_W'(1) << `EFLAGS_SF) |
    (`REG_W'(1) << `EFLAGS_OF);

  logic [`REG_W-1:0]   gpr [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [`REG_W-1:0]   eflags_q;
  logic                run_q;

  logic                wb_acc;
  logic                iss_acc;
  logic                iss_rdy;
  logic [`REG_W-1:0]   wb_merged;
  logic                rs_hit;
  logic                rt_hit;

  // run_q doubles as the RUN/RESET state: low in reset,
  // high from the first edge after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  assign wb_acc  = bus.wb_valid & run_q;
  assign iss_rdy = run_q &
                   (~busy_q[bus.iss_dst] | ~bus.iss_dst_we);
  assign iss_acc = bus.iss_valid & iss_rdy;

  // 32-bit writes zero-extend; 8/16-bit writes keep the
  // untouched upper part of the old register.
  always_comb begin
    wb_merged = bus.wb_data;
    unique case (1'b1)
      (bus.wb_bit_mode == `BIT_MODE_8):
        wb_merged = {gpr[bus.wb_dst][`REG_W-1:8],
                     bus.wb_data[7:0]};
      (bus.wb_bit_mode == `BIT_MODE_16):
        wb_merged = {gpr[bus.wb_dst][`REG_W-1:16],
                     bus.wb_data[15:0]};
      (bus.wb_bit_mode == `BIT_MODE_32):
        wb_merged = {{(`REG_W-32){1'b0}},
                     bus.wb_data[31:0]};
      (bus.wb_bit_mode == `BIT_MODE_64):
        wb_merged = bus.wb_data;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++)
        gpr[i] <= '0;
    end else if (wb_acc & bus.wb_we) begin
      gpr[bus.wb_dst] <= wb_merged;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eflags_q <= EFLAGS_INIT;
    end else if (wb_acc & bus.wb_flags_we) begin
      eflags_q <= (eflags_q & ~FLAG_MASK) |
                  (bus.wb_flags & FLAG_MASK);
    end
  end

  // Set after clear: a same-edge issue to the register
  // being retired is the newer producer.
  always_comb begin
    busy_d = busy_q;
    if (wb_acc & bus.wb_we)
      busy_d[bus.wb_dst] = 1'b0;
    if (iss_acc & bus.iss_dst_we)
      busy_d[bus.iss_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

`ifdef WB_BYPASS_EN
  assign rs_hit = wb_acc & bus.wb_we &
                  (bus.wb_dst == bus.rs_addr);
  assign rt_hit = wb_acc & bus.wb_we &
                  (bus.wb_dst == bus.rt_addr);
`else
  assign rs_hit = 1'b0;
  assign rt_hit = 1'b0;
`endif

  assign bus.rs_data = rs_hit ? wb_merged
                              : gpr[bus.rs_addr];
  assign bus.rt_data = rt_hit ? wb_merged
                              : gpr[bus.rt_addr];
  assign bus.rs_busy = ~rs_hit & busy_q[bus.rs_addr];
  assign bus.rt_busy = ~rt_hit & busy_q[bus.rt_addr];

  assign bus.iss_ready = iss_rdy;
  assign bus.wb_ready  = run_q;
  assign bus.eflags    = eflags_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: vector table, directed scoreboard/bypass
// sequences and random traffic against an array-based model.
`ifndef REG_W
`define REG_W 64
`endif
`ifndef BIT_MODE_W
`define BIT_MODE_W 2
`endif

module tb_writeback_regfile;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  writeback_regfile_if #(.REG_ADDR_W(4)) bus();

  writeback_regfile dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] m_gpr [16];
  bit          m_busy [16];
  logic [63:0] m_efl;
  bit          m_run;

  localparam logic [63:0] FMASK = 64'h8C5;

  typedef struct {
    logic        wb_we;
    logic [3:0]  dst;
    logic [63:0] data;
    logic [1:0]  mode;
    logic        flags_we;
    logic [63:0] flags;
    logic [63:0] exp_rs;
    logic [63:0] exp_efl;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(
    logic [63:0] old, logic [63:0] d, logic [1:0] mode);
    logic [63:0] low;
    if (mode == 2'd3) return d;
    if (mode == 2'd2) return d & 64'hFFFF_FFFF;
    low = (mode == 2'd0) ? 64'hFF : 64'hFFFF;
    return (old & ~low) | (d & low);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_gpr[i]  = '0;
      m_busy[i] = 0;
    end
    m_efl = 64'h2;
    m_run = 0;
  endtask

  task automatic idle();
    bus.iss_valid   = 0;
    bus.iss_dst     = '0;
    bus.iss_dst_we  = 0;
    bus.rs_addr     = '0;
    bus.rt_addr     = '0;
    bus.wb_valid    = 0;
    bus.wb_dst      = '0;
    bus.wb_we       = 0;
    bus.wb_data     = '0;
    bus.wb_bit_mode = '0;
    bus.wb_flags_we = 0;
    bus.wb_flags    = '0;
  endtask

  function automatic bit byp(logic [3:0] a);
`ifdef WB_BYPASS_EN
    return bus.wb_valid && m_run && bus.wb_we &&
           bus.wb_dst == a;
`else
    return a != a;
`endif
  endfunction

  // Called at posedge+1 with inputs driven: checks the
  // pre-edge outputs, takes the edge, advances the model.
  task automatic cycle_check();
    bit ia, wa, bs, bt;
    logic [63:0] mv;
    #2;
    ia = bus.iss_valid && m_run &&
         (!m_busy[bus.iss_dst] || !bus.iss_dst_we);
    wa = bus.wb_valid && m_run;
    mv = merge(m_gpr[bus.wb_dst], bus.wb_data,
               bus.wb_bit_mode);
    bs = byp(bus.rs_addr);
    bt = byp(bus.rt_addr);
    chk("iss_ready", 64'(bus.iss_ready),
        64'(m_run && (!m_busy[bus.iss_dst] ||
                      !bus.iss_dst_we)));
    chk("wb_ready", 64'(bus.wb_ready), 64'(m_run));
    chk("rs_data", bus.rs_data,
        bs ? mv : m_gpr[bus.rs_addr]);
    chk("rt_data", bus.rt_data,
        bt ? mv : m_gpr[bus.rt_addr]);
    chk("rs_busy", 64'(bus.rs_busy),
        64'(!bs && m_busy[bus.rs_addr]));
    chk("rt_busy", 64'(bus.rt_busy),
        64'(!bt && m_busy[bus.rt_addr]));
    chk("eflags", bus.eflags, m_efl);
    @(posedge clk);
    if (wa && bus.wb_we) begin
      m_gpr[bus.wb_dst]  = mv;
      m_busy[bus.wb_dst] = 0;
    end
    if (ia && bus.iss_dst_we) m_busy[bus.iss_dst] = 1;
    if (wa && bus.wb_flags_we)
      m_efl = (m_efl & ~FMASK) | (bus.wb_flags & FMASK);
    m_run = 1;
    #1;
  endtask

  task automatic wb_op(logic [3:0] d, logic [63:0] v,
                       logic [1:0] m);
    bus.wb_valid    = 1;
    bus.wb_we       = 1;
    bus.wb_dst      = d;
    bus.wb_data     = v;
    bus.wb_bit_mode = m;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 0,
               64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2};
    tbl[1] = '{1, 4'd0, 64'h12, 2'd0, 0,
               64'h0, 64'hFFFF_FFFF_FFFF_FF12, 64'h2};
    tbl[2] = '{1, 4'd0, 64'h3456, 2'd1, 0,
               64'h0, 64'hFFFF_FFFF_FFFF_3456, 64'h2};
    tbl[3] = '{1, 4'd0, 64'h89AB_CDEF, 2'd2, 0,
               64'h0, 64'h0000_0000_89AB_CDEF, 64'h2};
    tbl[4] = '{1, 4'd0, 64'h0123_4567_89AB_CDEF, 2'd3, 0,
               64'h0, 64'h0123_4567_89AB_CDEF, 64'h2};
    tbl[5] = '{0, 4'd0, 64'hDEAD, 2'd3, 1,
               64'h41, 64'h0123_4567_89AB_CDEF, 64'h43};
    tbl[6] = '{0, 4'd0, 64'hBEEF, 2'd0, 1,
               64'h0, 64'h0123_4567_89AB_CDEF, 64'h2};
    tbl[7] = '{0, 4'd0, 64'h0, 2'd1, 1,
               64'hFFFF_FFFF_FFFF_FFFF,
               64'h0123_4567_89AB_CDEF, 64'h8C7};

    idle();
    rstn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    cycle_check();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      bus.iss_valid   = $urandom_range(0, 1);
      bus.iss_dst     = 4'($urandom);
      bus.iss_dst_we  = ($urandom_range(0, 3) != 0);
      bus.rs_addr     = 4'($urandom);
      bus.rt_addr     = 4'($urandom);
      bus.wb_valid    = $urandom_range(0, 1);
      bus.wb_dst      = 4'($urandom);
      bus.wb_we       = ($urandom_range(0, 3) != 0);
      bus.wb_data     = {$urandom, $urandom};
      bus.wb_bit_mode = 2'($urandom);
      bus.wb_flags_we = ($urandom_range(0, 3) == 0);
      bus.wb_flags    = {$urandom, $urandom};
      cycle_check();
    end

    // reset mid-traffic, inputs still active
    bus.iss_valid  = 1;
    bus.iss_dst_we = 1;
    bus.wb_valid   = 1;
    rstn = 0;
    #1;
    for (int i = 0; i < 16; i++) begin
      bus.rs_addr = 4'(i);
      bus.rt_addr = 4'(15 - i);
      bus.iss_dst = 4'(i);
      bus.wb_we   = 0;
      #0.1;
      chk("rst_rs", bus.rs_data, 64'h0);
      chk("rst_rt", bus.rt_data, 64'h0);
      chk("rst_busy", 64'(bus.rs_busy | bus.rt_busy), 0);
    end
    chk("rst_eflags", bus.eflags, 64'h2);
    chk("rst_wb_ready", 64'(bus.wb_ready), 0);
    chk("rst_iss_ready", 64'(bus.iss_ready), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_wb_ready", 64'(bus.wb_ready), 0);
    idle();
    model_reset();
    rstn = 1;
    cycle_check();
    chk("post_rst_wb_ready", 64'(bus.wb_ready), 1);

    // width-merge and flag vectors
    for (int k = 0; k < 8; k++) begin
      idle();
      bus.wb_valid    = 1;
      bus.wb_we       = tbl[k].wb_we;
      bus.wb_dst      = tbl[k].dst;
      bus.wb_data     = tbl[k].data;
      bus.wb_bit_mode = tbl[k].mode;
      bus.wb_flags_we = tbl[k].flags_we;
      bus.wb_flags    = tbl[k].flags;
      cycle_check();
      idle();
      bus.rs_addr = tbl[k].dst;
      #1;
      chk($sformatf("tbl%0d_rs", k), bus.rs_data,
          tbl[k].exp_rs);
      chk($sformatf("tbl%0d_eflags", k), bus.eflags,
          tbl[k].exp_efl);
      cycle_check();
    end

    // scoreboard
    idle();
    bus.iss_valid = 1; bus.iss_dst = 3;
    bus.iss_dst_we = 1; bus.rs_addr = 3;
    #1 chk("sb_iss_ready_free", 64'(bus.iss_ready), 1);
    cycle_check();
    idle(); bus.rs_addr = 3;
    #1 chk("sb_busy_set", 64'(bus.rs_busy), 1);
    bus.iss_valid = 1; bus.iss_dst = 3; bus.iss_dst_we = 1;
    #1 chk("sb_waw_stall", 64'(bus.iss_ready), 0);
    bus.iss_dst_we = 0;
    #1 chk("sb_flags_only_ok", 64'(bus.iss_ready), 1);
    bus.iss_dst_we = 1;
    cycle_check();
    idle(); bus.rs_addr = 3;
    wb_op(4'd3, 64'h77, 2'd3);
`ifdef WB_BYPASS_EN
    #1 chk("sb_wb_cycle_busy", 64'(bus.rs_busy), 0);
`else
    #1 chk("sb_wb_cycle_busy", 64'(bus.rs_busy), 1);
`endif
    cycle_check();
    idle(); bus.rs_addr = 3;
    #1 chk("sb_busy_clear", 64'(bus.rs_busy), 0);
    chk("sb_data", bus.rs_data, 64'h77);
    bus.iss_valid = 1; bus.iss_dst = 3; bus.iss_dst_we = 1;
    wb_op(4'd3, 64'h88, 2'd3);
    cycle_check();
    idle(); bus.rs_addr = 3;
    #1 chk("sb_set_wins", 64'(bus.rs_busy), 1);
    wb_op(4'd3, 64'h99, 2'd3);
    cycle_check();

    // bypass
    idle();
    wb_op(4'd5, 64'h55, 2'd3);
    cycle_check();
    idle();
    bus.rs_addr = 5; bus.rt_addr = 5;
    wb_op(4'd5, 64'hAA, 2'd3);
`ifdef WB_BYPASS_EN
    #1 chk("byp_same_cycle", bus.rs_data, 64'hAA);
    chk("byp_same_cycle_t", bus.rt_data, 64'hAA);
`else
    #1 chk("byp_same_cycle", bus.rs_data, 64'h55);
    chk("byp_same_cycle_t", bus.rt_data, 64'h55);
`endif
    cycle_check();
    idle(); bus.rs_addr = 5;
    #1 chk("byp_next_cycle", bus.rs_data, 64'hAA);
    cycle_check();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
